// File: rtl/nf_ahb_pkg.sv
// Shared AHB-Lite constants and the master-interface FSM state type.
// Reused by the router and slaves so every block agrees on encodings.
package nf_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } ahb_mst_state_e;

  // size 3 is never legal; half needs addr[0]=0, word needs addr[1:0]=0
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    return (sz == 2'd3) || ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/nf_ahb_wait_cnt.sv
// Saturating data-phase wait counter; hit flags the stall cycle that brings
// the count to timeout_c so the FSM can abort on that same edge.
module nf_ahb_wait_cnt #(
  parameter int timeout_c = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);
  localparam int CW = $clog2(timeout_c + 1);

  logic [CW-1:0] cnt;

  assign hit = en && (cnt == CW'(timeout_c - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en && (cnt != CW'(timeout_c)))
      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/nf_ahb_master_if.sv
// Core load/store port to single non-burst AHB-Lite transfers, with local
// misalignment rejection and a data-phase stall timeout.
module nf_ahb_master_if
  import nf_ahb_pkg::*;
#(
  parameter int timeout_c = 16
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic [1:0]  size,
  output logic        ack,
  output logic [31:0] rd,
  output logic        err,
  output logic [31:0] haddr,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  output logic        hwrite,
  output logic [1:0]  htrans,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  input  logic [1:0]  hresp,
  input  logic        hready
);

  ahb_mst_state_e state;
  logic           to_hit;

  assign hburst = HBURST_SINGLE;

  nf_ahb_wait_cnt #(.timeout_c(timeout_c)) u_wait_cnt (
    .clk (hclk),
    .rst (hreset),
    .clr ((state == ST_ADDR) && hready),
    .en  ((state == ST_DATA) && !hready),
    .hit (to_hit)
  );

  // haddr/hwrite/hsize/hwdata double as the request latch
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state  <= ST_IDLE;
      ack    <= 1'b0;
      err    <= 1'b0;
      rd     <= '0;
      htrans <= HTRANS_IDLE;
      haddr  <= '0;
      hwdata <= '0;
      hwrite <= 1'b0;
      hsize  <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (is_misaligned(size, addr[1:0])) begin
              state <= ST_RESP;
              ack   <= 1'b1;
              err   <= 1'b1;
            end else begin
              state  <= ST_ADDR;
              htrans <= HTRANS_NONSEQ;
              haddr  <= addr;
              hwrite <= we;
              hsize  <= {1'b0, size};
              hwdata <= wd;
            end
          end
        end
        ST_ADDR: begin
          if (hready) begin
            state  <= ST_DATA;
            htrans <= HTRANS_IDLE;
          end
        end
        ST_DATA: begin
          // ERROR wins even in its first (hready=0) cycle
          if (hresp == HRESP_ERROR) begin
            state <= ST_RESP;
            ack   <= 1'b1;
            err   <= 1'b1;
          end else if (hready) begin
            state <= ST_RESP;
            ack   <= 1'b1;
            if (!hwrite) rd <= hrdata;
          end else if (to_hit) begin
            state <= ST_RESP;
            ack   <= 1'b1;
            err   <= 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nf_ahb_master_if.sv
// Directed bench: transaction-level expectations checked every cycle at negedge,
// plus literal latency/data checks per scenario.
module tb_nf_ahb_master_if;

  localparam int TO = 4;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wd = '0, hrdata = '0;
  logic [1:0]  size = '0, hresp = 2'b00;
  logic        hready = 1'b1;
  logic        ack, err, hwrite;
  logic [31:0] rd, haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;

  nf_ahb_master_if #(.timeout_c(TO)) dut (
    .hclk(hclk), .hreset(hreset), .req(req), .we(we), .addr(addr), .wd(wd),
    .size(size), .ack(ack), .rd(rd), .err(err), .haddr(haddr), .hwdata(hwdata),
    .hrdata(hrdata), .hwrite(hwrite), .htrans(htrans), .hsize(hsize),
    .hburst(hburst), .hresp(hresp), .hready(hready)
  );

  always #5 hclk = ~hclk;

  int n_chk = 0, n_fail = 0;
  int cyc_n = 0, t0 = 0, last_lat = 0, nonseq_cnt = 0;

  // expected outputs for the current cycle
  logic        chk_en = 1'b0, addr_ph = 1'b0, data_ph = 1'b0, rst_ph = 1'b0;
  logic        exp_ack = 1'b0, exp_err = 1'b0, exp_hwrite = 1'b0;
  logic [1:0]  exp_htrans = 2'b00;
  logic [2:0]  exp_hsize = 3'b000;
  logic [31:0] exp_rd = '0, exp_haddr = '0, exp_hwdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc_n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
    cyc_n++;
  endtask

  always @(negedge hclk) begin
    if (chk_en) begin
      chk("ack", 32'(ack), 32'(exp_ack));
      chk("err", 32'(err), 32'(exp_err));
      chk("htrans", 32'(htrans), 32'(exp_htrans));
      chk("hburst", 32'(hburst), 32'd0);
      chk("rd", rd, exp_rd);
      if (addr_ph) begin
        chk("haddr", haddr, exp_haddr);
        chk("hwrite", 32'(hwrite), 32'(exp_hwrite));
        chk("hsize", 32'(hsize), 32'(exp_hsize));
      end
      if (data_ph) chk("hwdata", hwdata, exp_hwdata);
      if (rst_ph) begin
        chk("rst_haddr", haddr, 32'd0);
        chk("rst_hwdata", hwdata, 32'd0);
        chk("rst_hwrite", 32'(hwrite), 32'd0);
        chk("rst_hsize", 32'(hsize), 32'd0);
      end
      if (ack) last_lat = cyc_n - t0 + 1;
      if (htrans == 2'b10) nonseq_cnt++;
    end
  end

  // mode: 0 = OKAY after dw waits, 1 = two-cycle ERROR, 2 = slave stalls forever
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input int aw, input int dw,
                        input int mode, input logic [31:0] hr);
    logic mis;
    mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    last_lat = 0;
    nonseq_cnt = 0;
    req = 1'b1; we = w; addr = a; wd = d; size = sz;
    tick();
    t0 = cyc_n;
    req = 1'b0;
    if (mis) begin
      exp_ack = 1'b1; exp_err = 1'b1;
      tick();
      exp_ack = 1'b0; exp_err = 1'b0;
      return;
    end
    addr_ph = 1'b1; exp_htrans = 2'b10;
    exp_haddr = a; exp_hwrite = w; exp_hsize = {1'b0, sz};
    for (int i = 0; i < aw; i++) begin hready = 1'b0; tick(); end
    hready = 1'b1;
    tick();
    addr_ph = 1'b0; data_ph = 1'b1; exp_htrans = 2'b00; exp_hwdata = d;
    if (mode == 0) begin
      for (int i = 0; i < dw; i++) begin hready = 1'b0; hrdata = $urandom; tick(); end
      hready = 1'b1; hresp = 2'b00; hrdata = hr;
      tick();
    end else if (mode == 1) begin
      hready = 1'b0; hresp = 2'b01; hrdata = hr;
      tick();
      hready = 1'b1;
    end else begin
      for (int i = 0; i < TO; i++) begin hready = 1'b0; tick(); end
    end
    data_ph = 1'b0;
    exp_ack = 1'b1; exp_err = (mode != 0);
    if (mode == 0 && !w) exp_rd = hr;
    tick();
    exp_ack = 1'b0; exp_err = 1'b0;
    hresp = 2'b00; hready = 1'b1; hrdata = $urandom;
  endtask

  initial begin
    // reset state
    tick();
    chk_en = 1'b1; rst_ph = 1'b1;
    tick();
    hreset = 1'b0;
    tick();
    rst_ph = 1'b0;
    chk("rst_rd_lit", rd, 32'd0);

    // word read, zero wait
    access(1'b0, 32'h0000_1004, 32'h1111_2222, 2'd2, 0, 0, 0, 32'hDEAD_BEEF);
    chk("rd_lat", 32'(last_lat), 32'd3);
    chk("rd_val", rd, 32'hDEAD_BEEF);
    chk("rd_nonseq", 32'(nonseq_cnt), 32'd1);
    tick();

    // byte write, 3 data-phase waits
    access(1'b1, 32'h0000_2003, 32'h0000_00A5, 2'd0, 0, 3, 0, 32'h5555_5555);
    chk("wr_lat", 32'(last_lat), 32'd6);
    chk("wr_rd_hold", rd, 32'hDEAD_BEEF);

    // misaligned half
    access(1'b0, 32'h0000_0001, 32'h0, 2'd1, 0, 0, 0, 32'h0);
    chk("mis_lat", 32'(last_lat), 32'd1);
    chk("mis_nonseq", 32'(nonseq_cnt), 32'd0);
    access(1'b1, 32'h0000_0010, 32'h0, 2'd3, 0, 0, 0, 32'h0);
    chk("mis3_lat", 32'(last_lat), 32'd1);

    // ERROR response on read, with one address-phase wait
    access(1'b0, 32'h0000_0040, 32'h0, 2'd2, 1, 0, 1, 32'hBAD0_BAD0);
    chk("errrsp_lat", 32'(last_lat), 32'd4);
    chk("errrsp_rd", rd, 32'hDEAD_BEEF);

    // stall timeout, then a normal half read
    access(1'b0, 32'h0000_0080, 32'h0, 2'd2, 0, 0, 2, 32'h0);
    chk("to_lat", 32'(last_lat), 32'd6);
    access(1'b0, 32'h0000_0012, 32'h0, 2'd1, 0, 2, 0, 32'h1234_5678);
    chk("post_to_lat", 32'(last_lat), 32'd5);
    chk("post_to_rd", rd, 32'h1234_5678);

    // reset during the data phase
    last_lat = 0;
    req = 1'b1; we = 1'b1; addr = 32'h0000_3000; wd = 32'hCAFE_F00D; size = 2'd2;
    tick();
    t0 = cyc_n; req = 1'b0;
    addr_ph = 1'b1; exp_htrans = 2'b10;
    exp_haddr = 32'h0000_3000; exp_hwrite = 1'b1; exp_hsize = 3'b010;
    tick();
    addr_ph = 1'b0; data_ph = 1'b1; exp_htrans = 2'b00; exp_hwdata = 32'hCAFE_F00D;
    hready = 1'b0; hreset = 1'b1;
    tick();
    data_ph = 1'b0; rst_ph = 1'b1; exp_rd = 32'd0;
    hreset = 1'b0; hready = 1'b1;
    tick();
    tick();
    rst_ph = 1'b0;
    chk("rst_no_ack", 32'(last_lat), 32'd0);

    access(1'b0, 32'h0000_1008, 32'h0, 2'd2, 0, 0, 0, 32'h0BAD_F00D);
    chk("final_lat", 32'(last_lat), 32'd3);
    chk("final_rd", rd, 32'h0BAD_F00D);
    tick();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc_n);
    $fatal(1, "watchdog");
  end

endmodule
